// File: rtl/req_priority_arbiter.sv
// Purpose : 4-way request arbiter with one-hot grant, grant hold, bounded hold with forced
//           preemption, optional round-robin order and a one-cycle dead handoff between owners.
// Latency : 1 cycle from req sampled at an edge to gnt; every owner change passes through one zero cycle.
// Backpressure: none; a requester holds its req bit until granted, and drops it to release the grant.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req[3:0]  request vector, bit i belongs to requester i
//   mode      0 = fixed priority (req[3] highest), 1 = round-robin after the last winner
//   gnt[3:0]  registered one-hot grant
//   gnt_id    index of the granted requester, 0 when nothing is granted
//   gnt_valid high whenever a grant bit is set
//   preempt   high during the handoff cycle that follows a forced release
module req_priority_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HANDOFF = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [1:0]         gnt_id_n;
  logic               gnt_valid_n;
  logic               preempt_n;
  logic [7:0]         hold_cnt, hold_cnt_n;
  logic [1:0]         last_id, last_id_n;
  logic [NUM_REQ-1:0] mask, mask_n;

  logic [NUM_REQ-1:0] cand;
  logic               win_vld;
  logic [1:0]         win_id;
  logic [1:0]         rr_idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  // Winner selection. Both loops run from lowest to highest priority so the
  // last hit overwrites earlier ones and the highest-priority set bit wins.
  always_comb begin
    cand    = req & ~mask;
    win_vld = |cand;
    win_id  = 2'd0;
    rr_idx  = 2'd0;
    if (!mode) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cand[i]) win_id = 2'(i);
      end
    end else begin
      // Search order last_id-1, -2, -3, -4 (== last_id) modulo 4; k=1 is checked last.
      for (int k = NUM_REQ; k >= 1; k--) begin
        rr_idx = last_id - 2'(k);
        if (cand[rr_idx]) win_id = rr_idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    preempt_n   = preempt;
    hold_cnt_n  = hold_cnt;
    last_id_n   = last_id;
    mask_n      = mask;
    unique case (state)
      // IDLE and HANDOFF arbitrate identically; mask is already zero in IDLE,
      // and both the mask and the preempt pulse last exactly one arbitration.
      IDLE, HANDOFF: begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_id_n    = 2'd0;
        gnt_valid_n = 1'b0;
        preempt_n   = 1'b0;
        mask_n      = '0;
        hold_cnt_n  = 8'd0;
        if (win_vld) begin
          state_n     = GRANT;
          gnt_n       = onehot(win_id);
          gnt_id_n    = win_id;
          gnt_valid_n = 1'b1;
          hold_cnt_n  = 8'd1;
          last_id_n   = win_id;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          // Voluntary release wins even when the hold limit is hit the same cycle.
          state_n     = HANDOFF;
          gnt_n       = '0;
          gnt_id_n    = 2'd0;
          gnt_valid_n = 1'b0;
          preempt_n   = 1'b0;
          mask_n      = '0;
        end else if (hold_cnt == MAX_HOLD_C && (req & ~onehot(gnt_id)) != '0) begin
          state_n     = HANDOFF;
          gnt_n       = '0;
          gnt_id_n    = 2'd0;
          gnt_valid_n = 1'b0;
          preempt_n   = 1'b1;
          mask_n      = onehot(gnt_id);
        end else if (hold_cnt != MAX_HOLD_C) begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_id_n    = 2'd0;
        gnt_valid_n = 1'b0;
        preempt_n   = 1'b0;
        mask_n      = '0;
        hold_cnt_n  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      hold_cnt  <= 8'd0;
      last_id   <= 2'd0;
      mask      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
      preempt   <= preempt_n;
      hold_cnt  <= hold_cnt_n;
      last_id   <= last_id_n;
      mask      <= mask_n;
    end
  end

endmodule

// File: doc/req_priority_arbiter.md
Name: req_priority_arbiter

Overview:
- Sequential arbiter that shares one downstream resource among 4 requesters using one-hot grants.
- Winner selection follows the team's 4-bit priority-encoder convention: the highest index wins, and the result is reported as a 2-bit id plus a valid flag.
- Adds grant hold, a bounded hold time with forced preemption, a round-robin mode and a one-cycle dead handoff between owners.
- Sits between requesting client blocks and a shared bus or datapath.

Parameters:
- NUM_REQ, 4, number of requesters. Fixed at 4; the id width is 2.
- MAX_HOLD, 8, maximum grant cycles while another requester waits. Legal range is 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i belongs to requester i.
- mode  input  1  0 = fixed priority (req[3] highest), 1 = round-robin.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  1 when any grant bit is set.
- preempt  output  1  one-cycle pulse, high during the handoff cycle that follows a forced release.

Behaviour:
- Reset (asynchronous assert, rst_n=0) drives state to IDLE and the following values:
  - gnt=0, gnt_id=0, gnt_valid=0, preempt=0.
  - hold_cnt=0, last_id=0, mask=0.
- Release of reset is synchronous to clk. Reset asserted mid-grant drops gnt immediately, with no handoff cycle.
- All outputs are registered. req is sampled at the edge and gnt appears in the following cycle, so latency is 1 cycle from req to gnt.
- Arbitration function (evaluated in IDLE and HANDOFF):
  - cand = req & ~mask.
  - mode=0: the winner is the highest set index of cand.
  - mode=1: search order is last_id-1, last_id-2, last_id-3, last_id (mod 4), and the first set bit of cand wins. After reset (last_id=0) the order is 3,2,1,0, the same as fixed priority.
  - mode is sampled only at arbitration edges; a change during GRANT takes effect at the next arbitration.
- States:
  - IDLE: if cand==0, stay in IDLE. Otherwise go to GRANT with gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=1, last_id=winner.
  - GRANT, owner o:
    - req[o]=0 at the edge: go to HANDOFF with a normal release (preempt=0, mask=0).
    - req[o]=1, hold_cnt==MAX_HOLD, and (req & ~onehot(o))!=0: go to HANDOFF with a forced release (preempt=1, mask=onehot(o)).
    - Otherwise stay in GRANT; hold_cnt increments, saturating at MAX_HOLD.
    - Consequences: with no competitor the owner keeps the grant indefinitely, and a preempted owner holds exactly MAX_HOLD cycles.
  - HANDOFF: gnt=0 and gnt_valid=0 for exactly one cycle.
    - Arbitrate using the current mask. A winner takes the GRANT entry actions as from IDLE; otherwise go to IDLE.
    - mask clears on leaving HANDOFF. It applies to one arbitration only, so a masked requester can win the next one.
    - preempt clears on leaving HANDOFF.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt never changes owner without an intervening zero cycle.
  - gnt_id==index(gnt) whenever gnt_valid=1.
  - A grant is never issued to a bit that was 0 at the arbitration edge.
- Simultaneous events:
  - Owner drops req in the same cycle hold_cnt hits MAX_HOLD: this is a normal release with preempt=0.
  - In HANDOFF with only the masked requester pending: the mask excludes it, the block goes to IDLE, and it is re-granted 1 cycle later.
- hold_cnt width is 8 bits.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, gnt_valid=0, preempt=0. Release reset with req=4'b0101, mode=0 -> next cycle gnt=4'b0100, gnt_id=2.
- Fixed priority, normal release: req=4'b1010 held; then req[3] drops after 3 grant cycles -> gnt=1000 for 3 cycles, one zero cycle, then gnt=0010, gnt_id=1.
- Forced preemption, MAX_HOLD=8: req=4'b1001 held continuously -> gnt=1000 for exactly 8 cycles, then HANDOFF with preempt=1 and gnt=0. Next cycle gnt=0001; after 8 more cycles, preempt again and gnt returns to 1000.
- No competitor: req=4'b0100 for 20 cycles -> gnt=0100 continuously, preempt never asserts.
- Round-robin: mode=1, each requester drops req after 1 grant cycle, all four re-asserting -> grant order 3,2,1,0,3, each separated by one zero cycle.
- Reset mid-operation and masked-only case: assert rst_n=0 during GRANT -> gnt=0 asynchronously. Separately, after a forced release of owner 3, drop the other requests -> IDLE for one cycle, then gnt=1000 again.
